// File: rtl/alu_pm_core_32.sv
`default_nettype none
// ============================================================================
// Module      : alu_pm_core_32
// Description : 32-bit CLA add/sub and logic ALU with a programmable clock
//               divider and per-unit glitch-free clock gating.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pm_core_32 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Opcode,
    input  logic [1:0]       Power_Mode,
    input  logic             Enable,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Clk_Scaled
);

    localparam int         c_GROUPS = WIDTH / 4;
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;

    logic [2:0]       r_cnt;
    logic [1:0]       r_mode;
    logic [1:0]       r_sel;
    logic             r_on;
    logic             r_en_arith;
    logic             r_en_logic;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic             w_arith_req;
    logic             w_logic_req;
    logic             w_gclk_arith;
    logic             w_gclk_logic;
    logic             w_gclk_result;
    logic             w_sub;
    logic             w_cin;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_bg;
    logic [WIDTH-1:0] w_bp;
    logic [WIDTH-1:0] w_sum;
    logic [c_GROUPS-1:0] w_grp_g;
    logic [c_GROUPS-1:0] w_grp_p;
    logic [c_GROUPS:0]   w_gcarry;
    logic             w_term;
    logic             w_prop;
    logic [WIDTH-1:0] w_next_result;
    logic             w_next_cout;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt  <= 3'd0;
            r_mode <= 2'b00;
        end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_mode <= Power_Mode;
            end
        end
    end

    // The output mux only switches on the falling edge after the counter wraps,
    // when Clk and every counter bit are low, so no source change can cut a phase.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sel <= 2'b00;
            r_on  <= 1'b0;
        end else begin
            r_sel <= r_mode;
            r_on  <= 1'b1;
        end
    end

    always_comb begin
        case (r_sel)
            2'b00:   Clk_Scaled = Clk & r_on;
            2'b01:   Clk_Scaled = r_cnt[0];
            2'b10:   Clk_Scaled = r_cnt[1];
            default: Clk_Scaled = r_cnt[2];
        endcase
    end

    assign w_arith_req = Enable & ((Opcode == c_OP_ADD) | (Opcode == c_OP_SUB));
    assign w_logic_req = Enable & (Opcode >= c_OP_AND) & (Opcode <= c_OP_NOT);

    always_latch begin
        if (!Rst_n) begin
            r_en_arith <= 1'b0;
            r_en_logic <= 1'b0;
        end else if (!Clk_Scaled) begin
            r_en_arith <= w_arith_req;
            r_en_logic <= w_logic_req;
        end
    end

    assign w_gclk_arith  = Clk_Scaled & r_en_arith;
    assign w_gclk_logic  = Clk_Scaled & r_en_logic;
    // Unit enables are mutually exclusive, so at most one gated clock pulses per edge.
    assign w_gclk_result = w_gclk_arith | w_gclk_logic;

    assign w_sub   = (Opcode == c_OP_SUB);
    assign w_cin   = w_sub;
    assign w_b_eff = w_sub ? ~B : B;
    assign w_bg    = A & w_b_eff;
    assign w_bp    = A ^ w_b_eff;

    for (genvar gi = 0; gi < c_GROUPS; gi++) begin : g_grp
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_c;

        assign w_g    = w_bg[4*gi +: 4];
        assign w_p    = w_bp[4*gi +: 4];
        assign w_c[0] = w_gcarry[gi];
        assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        assign w_grp_g[gi] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        assign w_grp_p[gi] = &w_p;
        assign w_sum[4*gi +: 4] = w_p ^ w_c;
    end

    // Each group carry is a flat sum of products over lower groups, not a ripple chain.
    always_comb begin
        w_gcarry    = '0;
        w_gcarry[0] = w_cin;
        w_term      = 1'b0;
        w_prop      = 1'b1;
        for (int i = 0; i < c_GROUPS; i++) begin
            w_term = 1'b0;
            w_prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_term = w_term | (w_grp_g[j] & w_prop);
                w_prop = w_prop & w_grp_p[j];
            end
            w_gcarry[i+1] = w_term | (w_cin & w_prop);
        end
    end

    always_comb begin
        w_next_result = r_result;
        w_next_cout   = r_cout;
        case (Opcode)
            c_OP_ADD: begin
                w_next_result = w_sum;
                w_next_cout   = w_gcarry[c_GROUPS];
            end
            c_OP_SUB: begin
                w_next_result = w_sum;
                w_next_cout   = ~w_gcarry[c_GROUPS];
            end
            c_OP_AND: begin
                w_next_result = A & B;
                w_next_cout   = 1'b0;
            end
            c_OP_OR: begin
                w_next_result = A | B;
                w_next_cout   = 1'b0;
            end
            c_OP_XOR: begin
                w_next_result = A ^ B;
                w_next_cout   = 1'b0;
            end
            c_OP_NOT: begin
                w_next_result = ~A;
                w_next_cout   = 1'b0;
            end
            default: begin
                w_next_result = r_result;
                w_next_cout   = r_cout;
            end
        endcase
    end

    always_ff @(posedge w_gclk_result or negedge Rst_n) begin
        if (!Rst_n) begin
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_result <= w_next_result;
            r_cout   <= w_next_cout;
        end
    end

    assign Result = r_result;
    assign Cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_alu_pm_core_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pm_core_32
// Description : Self-checking bench for alu_pm_core_32 against a cycle-level
//               divider/ALU reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pm_core_32;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  Opcode;
    logic [1:0]  Power_Mode;
    logic        Enable;
    logic [31:0] Result;
    logic        Cout;
    logic        Clk_Scaled;

    int checks = 0;
    int errors = 0;
    int runts  = 0;
    time last_t = 0;

    // reference model state
    logic [2:0]  m_cnt;
    logic [1:0]  m_mode;
    int          m_sel;
    logic        m_on;
    logic        m_upd;
    logic [31:0] exp_res;
    logic        exp_cout;

    alu_pm_core_32 #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .A          (A),
        .B          (B),
        .Opcode     (Opcode),
        .Power_Mode (Power_Mode),
        .Enable     (Enable),
        .Result     (Result),
        .Cout       (Cout),
        .Clk_Scaled (Clk_Scaled)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(Clk_Scaled) begin
        if (Rst_n && last_t != 0 && ($time - last_t) < 5) runts++;
        last_t = $time;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 3'd0;
        m_mode   = 2'b00;
        m_sel    = 0;
        m_on     = 1'b0;
        m_upd    = 1'b0;
        exp_res  = 32'h0;
        exp_cout = 1'b0;
    endtask

    task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] wide;
        case (op)
            3'd0: begin
                wide     = {1'b0, a} + {1'b0, b};
                exp_res  = wide[31:0];
                exp_cout = wide[32];
            end
            3'd1: begin
                exp_res  = a - b;
                exp_cout = (a < b);
            end
            3'd2: begin exp_res = a & b; exp_cout = 1'b0; end
            3'd3: begin exp_res = a | b; exp_cout = 1'b0; end
            3'd4: begin exp_res = a ^ b; exp_cout = 1'b0; end
            default: begin exp_res = ~a; exp_cout = 1'b0; end
        endcase
    endtask

    // One Clk period: model the scaled edge, then check high and low halves.
    task automatic step();
        logic [1:0] pm;
        logic [2:0] old_cnt;
        logic       rise;
        logic       lvl;
        pm = Power_Mode;
        @(posedge Clk);
        old_cnt = m_cnt;
        m_cnt   = m_cnt + 3'd1;
        if (m_sel == 0) rise = m_on;
        else            rise = m_cnt[m_sel-1] && !old_cnt[m_sel-1];
        if (old_cnt == 3'd7) m_mode = pm;
        if (rise && Enable && (Opcode <= 3'd5)) begin
            ref_op(A, B, Opcode);
            m_upd = 1'b1;
        end
        #1;
        lvl = (m_sel == 0) ? m_on : m_cnt[m_sel-1];
        check("step_result", Result, exp_res);
        check("step_cout", {31'b0, Cout}, {31'b0, exp_cout});
        check("scaled_high_half", {31'b0, Clk_Scaled}, {31'b0, lvl});
        @(negedge Clk);
        m_sel = int'(m_mode);
        m_on  = 1'b1;
        #1;
        lvl = (m_sel == 0) ? 1'b0 : m_cnt[m_sel-1];
        check("scaled_low_half", {31'b0, Clk_Scaled}, {31'b0, lvl});
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] er, input logic ec);
        A      = a;
        B      = b;
        Opcode = op;
        Enable = 1'b1;
        m_upd  = 1'b0;
        for (int k = 0; k < 20 && !m_upd; k++) step();
        check({tag, "_timeout"}, {31'b0, m_upd}, 32'h1);
        check({tag, "_result"}, Result, er);
        check({tag, "_cout"}, {31'b0, Cout}, {31'b0, ec});
    endtask

    initial begin
        Rst_n      = 1'b0;
        A          = 32'h0;
        B          = 32'h0;
        Opcode     = 3'd0;
        Power_Mode = 2'b00;
        Enable     = 1'b0;
        model_reset();

        repeat (2) @(negedge Clk);
        #1;
        check("reset_result", Result, 32'h0);
        check("reset_cout", {31'b0, Cout}, 32'h0);
        check("reset_scaled_low", {31'b0, Clk_Scaled}, 32'h0);
        @(posedge Clk);
        #1;
        check("reset_scaled_high", {31'b0, Clk_Scaled}, 32'h0);
        @(negedge Clk);
        #2 Rst_n = 1'b1;

        run_op("add_5_3",   32'h5, 32'h3, 3'd0, 32'h8, 1'b0);
        run_op("add_wrap",  32'hFFFF_FFFF, 32'h1, 3'd0, 32'h0, 1'b1);
        run_op("sub_5_3",   32'h5, 32'h3, 3'd1, 32'h2, 1'b0);
        run_op("sub_3_5",   32'h3, 32'h5, 3'd1, 32'hFFFF_FFFE, 1'b1);
        run_op("sub_7_0",   32'h7, 32'h0, 3'd1, 32'h7, 1'b0);
        run_op("sub_3_5b",  32'h3, 32'h5, 3'd1, 32'hFFFF_FFFE, 1'b1);
        run_op("and",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 32'h00F0_00F0, 1'b0);
        run_op("or",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd3, 32'hFFF0_FFF0, 1'b0);
        run_op("xor",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 32'hFF00_FF00, 1'b0);
        run_op("not",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd5, 32'h0F0F_0F0F, 1'b0);

        Enable = 1'b0;
        Opcode = 3'd0;
        for (int k = 0; k < 10; k++) begin
            A = $urandom;
            B = $urandom;
            step();
        end
        check("hold_disabled_result", Result, 32'h0F0F_0F0F);
        check("hold_disabled_cout", {31'b0, Cout}, 32'h0);

        Enable = 1'b1;
        Opcode = 3'b110;
        for (int k = 0; k < 10; k++) begin
            A = $urandom;
            B = $urandom;
            step();
        end
        check("hold_op110_result", Result, 32'h0F0F_0F0F);

        Power_Mode = 2'b01;
        repeat (10) step();
        run_op("m01_sub", 32'h3, 32'h5, 3'd1, 32'hFFFF_FFFE, 1'b1);
        Power_Mode = 2'b10;
        repeat (10) step();
        run_op("m10_add", 32'hFFFF_FFFF, 32'h1, 3'd0, 32'h0, 1'b1);
        Power_Mode = 2'b11;
        repeat (10) step();
        run_op("m11_xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 32'hFF00_FF00, 1'b0);

        Opcode = 3'd0;
        for (int k = 0; k < 32; k++) begin
            A      = $urandom;
            B      = $urandom;
            Enable = ~Enable;
            step();
        end

        Power_Mode = 2'b10;
        repeat (12) step();
        Power_Mode = 2'b00;
        #2 Rst_n = 1'b0;
        #1;
        check("midreset_result", Result, 32'h0);
        check("midreset_cout", {31'b0, Cout}, 32'h0);
        check("midreset_scaled", {31'b0, Clk_Scaled}, 32'h0);
        @(posedge Clk);
        #1;
        check("midreset_scaled_high", {31'b0, Clk_Scaled}, 32'h0);
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        model_reset();
        run_op("post_reset_add", 32'h1234_0000, 32'h0000_5678, 3'd0, 32'h1234_5678, 1'b0);

        for (int k = 0; k < 600; k++) begin
            A      = $urandom;
            B      = ($urandom_range(0, 7) == 0) ? A : $urandom;
            Opcode = 3'($urandom_range(0, 7));
            Enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) Power_Mode = 2'($urandom_range(0, 3));
            step();
        end

        check("runt_pulses", runts, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
